// File: rtl/inst_buffer_pkg.sv
// rtl/inst_buffer_pkg.sv - shared widths, entry type and helpers for the instruction buffer
package inst_buffer_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  // One queue slot: the instruction word and the PC it was fetched from
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } ib_entry_t;

  // Number of valid slots in a fetch pair mask
  function automatic logic [1:0] mask_popcount(input logic [1:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]};
  endfunction

  // Decode can never take more than two per cycle; 3 is treated as 2
  function automatic logic [1:0] clamp_issue(input logic [1:0] c);
    return (c == 2'd3) ? 2'd2 : c;
  endfunction

endpackage

// File: rtl/inst_buffer_if.sv
// rtl/inst_buffer_if.sv - fetch write, decode pop and status signals of the instruction buffer
interface inst_buffer_if #(
  parameter int DEPTH = 16
) ();
  import inst_buffer_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              wen;
  logic [1:0]        wmask;
  logic [ADDR_W-1:0] wpc;
  logic [INST_W-1:0] winst0;
  logic [INST_W-1:0] winst1;
  logic [1:0]        issue_cnt;
  logic              stall_id;
  logic [INST_W-1:0] inst0;
  logic [ADDR_W-1:0] pc0;
  logic              valid0;
  logic [INST_W-1:0] inst1;
  logic [ADDR_W-1:0] pc1;
  logic              valid1;
  logic              ibuffer_full;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, wen, wmask, wpc, winst0, winst1, issue_cnt, stall_id,
    input  inst0, pc0, valid0, inst1, pc1, valid1, ibuffer_full, count
  );

  modport slave (
    input  flush, wen, wmask, wpc, winst0, winst1, issue_cnt, stall_id,
    output inst0, pc0, valid0, inst1, pc1, valid1, ibuffer_full, count
  );

endinterface

// File: rtl/inst_buffer_ib_ram.sv
// rtl/inst_buffer_ib_ram.sv - entry storage with two write ports and two asynchronous read ports
module ib_ram
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we0,
  input  logic [PTR_W-1:0] waddr0,
  input  ib_entry_t        wdata0,
  input  logic             we1,
  input  logic [PTR_W-1:0] waddr1,
  input  ib_entry_t        wdata1,
  input  logic [PTR_W-1:0] raddr0,
  input  logic [PTR_W-1:0] raddr1,
  output ib_entry_t        rdata0,
  output ib_entry_t        rdata1
);

  ib_entry_t mem [DEPTH];

  // Storage needs no reset: validity is tracked entirely by the pointers and count
  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/inst_buffer.sv
// rtl/inst_buffer.sv - fetch-to-decode instruction queue with dual-issue read port
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int FULL_MARGIN = 4
) (
  input  logic     clk,
  input  logic     rst,
  inst_buffer_if.slave ib
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic [1:0]       wcnt;
  logic [1:0]       req;
  logic [CNT_W-1:0] wcnt_w;
  logic [CNT_W-1:0] req_w;
  logic [CNT_W-1:0] rcnt_w;
  logic [CNT_W-1:0] free_after_pop;
  logic             do_write;

  ib_entry_t wdata0;
  ib_entry_t wdata1;
  ib_entry_t rdata0;
  ib_entry_t rdata1;

  logic             out_valid0;
  logic             out_valid1;

  // Write/pop amounts; an oversized write is dropped whole after crediting this cycle's pop
  always_comb begin
    wcnt           = ib.wen ? mask_popcount(ib.wmask) : 2'd0;
    req            = ib.stall_id ? 2'd0 : clamp_issue(ib.issue_cnt);
    wcnt_w         = CNT_W'(wcnt);
    req_w          = CNT_W'(req);
    rcnt_w         = (req_w > count_q) ? count_q : req_w;
    free_after_pop = CNT_W'(DEPTH) - count_q + rcnt_w;
    do_write       = (wcnt != 2'd0) && (wcnt_w <= free_after_pop) && !ib.flush && !rst;
  end

  // Pack the fetch pair so valid slots land contiguously starting at tail
  always_comb begin
    wdata1.inst = ib.winst1;
    wdata1.pc   = ib.wpc + 32'd4;
    if (ib.wmask[0]) begin
      wdata0.inst = ib.winst0;
      wdata0.pc   = ib.wpc;
    end else begin
      wdata0 = wdata1;
    end
  end

  ib_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk    (clk),
    .we0    (do_write),
    .waddr0 (tail_q),
    .wdata0 (wdata0),
    .we1    (do_write && (ib.wmask == 2'b11)),
    .waddr1 (tail_q + PTR_W'(1)),
    .wdata1 (wdata1),
    .raddr0 (head_q),
    .raddr1 (head_q + PTR_W'(1)),
    .rdata0 (rdata0),
    .rdata1 (rdata1)
  );

  // Pointer and occupancy update; reset and flush both empty the queue
  always_ff @(posedge clk) begin
    if (rst || ib.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_q + rcnt_w[PTR_W-1:0];
      if (do_write) tail_q <= tail_q + PTR_W'(wcnt);
      count_q <= count_q - rcnt_w + (do_write ? wcnt_w : '0);
    end
  end

  // Read port straight from head; outputs are quiet during reset and the flush cycle
  always_comb begin
    out_valid0      = !rst && !ib.flush && (count_q >= CNT_W'(1));
    out_valid1      = !rst && !ib.flush && (count_q >= CNT_W'(2));
    ib.valid0       = out_valid0;
    ib.valid1       = out_valid1;
    ib.inst0        = out_valid0 ? rdata0.inst : '0;
    ib.pc0          = out_valid0 ? rdata0.pc   : '0;
    ib.inst1        = out_valid1 ? rdata1.inst : '0;
    ib.pc1          = out_valid1 ? rdata1.pc   : '0;
    ib.count        = rst ? '0 : count_q;
    ib.ibuffer_full = !rst && ((CNT_W'(DEPTH) - count_q) < CNT_W'(FULL_MARGIN));
  end

endmodule

// File: tb/tb_inst_buffer.sv
// tb/tb_inst_buffer.sv - scoreboard bench for inst_buffer
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_buffer_if #(.DEPTH(16)) ibus ();

  inst_buffer #(
    .DEPTH       (16),
    .FULL_MARGIN (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ib  (ibus.slave)
  );

  int total = 0;
  int bad   = 0;
  ib_entry_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Apply one cycle of stimulus just after the edge; accepted writes go to the scoreboard
  task automatic drive(input logic fl, input logic we, input logic [1:0] mask,
                       input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [1:0] iss, input logic st, input logic accept);
    ib_entry_t e;
    @(posedge clk);
    #1;
    ibus.flush     = fl;
    ibus.wen       = we;
    ibus.wmask     = mask;
    ibus.wpc       = pc;
    ibus.winst0    = i0;
    ibus.winst1    = i1;
    ibus.issue_cnt = iss;
    ibus.stall_id  = st;
    if (fl) begin
      exp_q.delete();
    end else if (we && accept) begin
      if (mask[0]) begin
        e.inst = i0; e.pc = pc;
        exp_q.push_back(e);
      end
      if (mask[1]) begin
        e.inst = i1; e.pc = pc + 32'd4;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);
  endtask

  task automatic pair(input logic [31:0] pc, input logic [1:0] iss, input logic st);
    drive(1'b0, 1'b1, 2'b11, pc, {16'hA000, pc[15:0]}, {16'hB000, pc[15:0] + 16'd4}, iss, st, 1'b1);
  endtask

  // Monitor: compare every instruction decode actually takes against the scoreboard
  always @(negedge clk) begin
    if (rst === 1'b0 && ibus.flush === 1'b0 && ibus.stall_id === 1'b0) begin
      automatic int n = (ibus.issue_cnt == 2'd3) ? 2 : int'(ibus.issue_cnt);
      for (int k = 0; k < n; k++) begin
        automatic logic v = (k == 0) ? ibus.valid0 : ibus.valid1;
        automatic logic [31:0] apc = (k == 0) ? ibus.pc0 : ibus.pc1;
        automatic logic [31:0] ain = (k == 0) ? ibus.inst0 : ibus.inst1;
        ib_entry_t e;
        if (!v) break;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_unexpected: got pc 0x%08h expected no entry", apc);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("pop%0d_pc", k), apc, e.pc);
          check($sformatf("pop%0d_inst", k), ain, e.inst);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst            = 1'b1;
    ibus.flush     = 1'b0;
    ibus.wen       = 1'b0;
    ibus.wmask     = 2'b00;
    ibus.wpc       = '0;
    ibus.winst0    = '0;
    ibus.winst1    = '0;
    ibus.issue_cnt = 2'd0;
    ibus.stall_id  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_count", 32'(ibus.count), 32'd0);
    check("rst_valid0", 32'(ibus.valid0), 32'd0);
    check("rst_valid1", 32'(ibus.valid1), 32'd0);
    check("rst_full", 32'(ibus.ibuffer_full), 32'd0);
    check("rst_pc0", ibus.pc0, 32'd0);
    check("rst_inst0", ibus.inst0, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // First pair, no bypass while empty
    drive(1'b0, 1'b1, 2'b11, 32'hbfc00000, 32'h11111111, 32'h22222222, 2'd0, 1'b0, 1'b1);
    #1 check("nobypass_valid0", 32'(ibus.valid0), 32'd0);
    idle();
    #1;
    check("t1_valid0", 32'(ibus.valid0), 32'd1);
    check("t1_valid1", 32'(ibus.valid1), 32'd1);
    check("t1_pc0", ibus.pc0, 32'hbfc00000);
    check("t1_pc1", ibus.pc1, 32'hbfc00004);
    check("t1_inst0", ibus.inst0, 32'h11111111);
    check("t1_inst1", ibus.inst1, 32'h22222222);
    check("t1_count", 32'(ibus.count), 32'd2);

    // Mask 10 into an empty buffer
    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 2'b10, 32'hbfc00008, 32'h0, 32'h33333333, 2'd0, 1'b0, 1'b1);
    idle();
    #1;
    check("t2_valid0", 32'(ibus.valid0), 32'd1);
    check("t2_pc0", ibus.pc0, 32'hbfc0000c);
    check("t2_inst0", ibus.inst0, 32'h33333333);
    check("t2_valid1", 32'(ibus.valid1), 32'd0);

    // Fill to full, then overflow
    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      pair(32'h1000 + 32'(8 * i), 2'd0, 1'b0);
      #1;
      check("fill_count", 32'(ibus.count), 32'(2 * i));
      check("fill_full", 32'(ibus.ibuffer_full), 32'd0);
    end
    idle();
    #1;
    check("c14_count", 32'(ibus.count), 32'd14);
    check("c14_full", 32'(ibus.ibuffer_full), 32'd1);
    drive(1'b0, 1'b1, 2'b01, 32'h1038, 32'hA0001038, 32'h0, 2'd0, 1'b0, 1'b1);
    idle();
    #1 check("c15_count", 32'(ibus.count), 32'd15);
    drive(1'b0, 1'b1, 2'b11, 32'h1040, 32'hDEAD0000, 32'hDEAD0004, 2'd0, 1'b0, 1'b0);
    idle();
    #1;
    check("ovf_count", 32'(ibus.count), 32'd15);
    check("ovf_full", 32'(ibus.ibuffer_full), 32'd1);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b1);
    idle();
    #1;
    check("drain_count", 32'(ibus.count), 32'd0);
    check("drain_valid0", 32'(ibus.valid0), 32'd0);

    // Sustained write+pop across several wraps, then stall
    pair(32'h2000, 2'd0, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      pair(32'h2000 + 32'(8 * i), 2'd2, 1'b0);
      #1 check("wrap_count", 32'(ibus.count), 32'd2);
    end
    for (int j = 0; j < 3; j++) begin
      pair(32'h20f8 + 32'(8 * j), 2'd2, 1'b1);
      #1 check("stall_count", 32'(ibus.count), 32'(2 + 2 * j));
    end
    idle();
    #1 check("stall_end_count", 32'(ibus.count), 32'd8);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b1);
    idle();
    #1 check("wrap_drain_count", 32'(ibus.count), 32'd0);

    // Pop clamped by occupancy while writing
    drive(1'b0, 1'b1, 2'b01, 32'h3000, 32'hC0003000, 32'h0, 2'd0, 1'b0, 1'b1);
    idle();
    #1 check("c1_count", 32'(ibus.count), 32'd1);
    pair(32'h3100, 2'd2, 1'b0);
    idle();
    #1;
    check("clamp_count", 32'(ibus.count), 32'd2);
    check("clamp_pc0", ibus.pc0, 32'h3100);

    // Flush at count 10 with a write and pop pending
    for (int i = 0; i < 4; i++) pair(32'h3200 + 32'(8 * i), 2'd0, 1'b0);
    idle();
    #1 check("c10_count", 32'(ibus.count), 32'd10);
    drive(1'b1, 1'b1, 2'b11, 32'h4000, 32'hE0004000, 32'hE0004004, 2'd2, 1'b0, 1'b1);
    #1;
    check("flush_valid0", 32'(ibus.valid0), 32'd0);
    check("flush_valid1", 32'(ibus.valid1), 32'd0);
    check("flush_pc0", ibus.pc0, 32'd0);
    idle();
    #1;
    check("postflush_count", 32'(ibus.count), 32'd0);
    check("postflush_full", 32'(ibus.ibuffer_full), 32'd0);
    check("postflush_valid0", 32'(ibus.valid0), 32'd0);
    pair(32'h5000, 2'd0, 1'b0);
    idle();
    #1;
    check("first_after_flush_pc0", ibus.pc0, 32'h5000);
    check("first_after_flush_valid0", 32'(ibus.valid0), 32'd1);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b1);
    idle();
    #1;
    check("final_count", 32'(ibus.count), 32'd0);
    check("scoreboard_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Fetch-side instruction queue between the icache read-data return and the decode stage.
- Accepts up to two instructions per cycle: an aligned pair at fetch_pc and fetch_pc+4, with a per-slot valid mask.
- Presents up to two oldest instructions with their PCs to decode, which pops 0, 1 or 2 per cycle.
- Generates ibuffer_full, which throttles the PC register and icache requests. Flushes on exception or branch mispredict.

Parameters:
- DEPTH, 16: number of entries; power of two, minimum 8.
- FULL_MARGIN, 4: ibuffer_full asserts when free entries < FULL_MARGIN. This absorbs in-flight icache returns after the request is dropped.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush (`Flush)
- wen  in  1  icache returns fetch data this cycle
- wmask  in  2  bit0 = inst0 valid, bit1 = inst1 valid
- wpc  in  32  PC of inst0 slot (`InstAddrBus); inst1 PC = wpc+4
- winst0  in  32  instruction at wpc
- winst1  in  32  instruction at wpc+4
- issue_cnt  in  2  decode pop request: 0, 1 or 2 (3 treated as 2)
- stall_id  in  1  decode stalled; no pop
- inst0  out  32  oldest instruction
- pc0  out  32  PC of inst0
- valid0  out  1  inst0/pc0 meaningful
- inst1  out  32  second-oldest instruction
- pc1  out  32  PC of inst1
- valid1  out  1  inst1/pc1 meaningful
- ibuffer_full  out  1  throttle to PC register / icache request
- count  out  log2(DEPTH)+1  occupancy, for debug

Behaviour:
- Storage: circular array of {inst, pc}; head, tail, count registers.
- Write count: wcnt = popcount(wmask) when wen, else 0.
- Write packing: mask 11 writes inst0 at tail and inst1 at tail+1; 01 writes inst0 at tail; 10 writes inst1 (pc = wpc+4) at tail; 00 writes nothing.
  - tail advances by wcnt modulo DEPTH; wrap is pointer-width truncation.
- Pop count: rcnt = 0 if stall_id; else min(issue_cnt clamped to 2, count).
  - head advances by rcnt modulo DEPTH.
- Occupancy: count_next = count + wcnt - rcnt. Simultaneous write and pop is legal at any occupancy, including empty.
- Read port is combinational from head:
  - valid0 = (count >= 1); valid1 = (count >= 2).
  - inst/pc outputs are 0 whenever the matching valid is 0.
- Write-to-read latency: data written at edge N is visible at the outputs in cycle N+1. There is no bypass while empty.
- Full flag: ibuffer_full = (DEPTH - count) < FULL_MARGIN; combinational from registered count.
- Overflow: a write whose wcnt exceeds free entries (evaluated after the same-cycle pop) is dropped entirely. Pointers are unchanged for that write. Given FULL_MARGIN this is a protocol violation; the bench flags it.
- Flush: when flush=1, at the next edge head = tail = count = 0.
  - Same-cycle writes and pops are ignored.
  - valid0/valid1 are forced 0 during the flush cycle itself.
- Reset: rst=1 gives the same state as flush. All outputs are 0 during and after reset until the first write: valid0=valid1=0, inst/pc=0, ibuffer_full=0, count=0.
- rst has priority over flush; flush has priority over write and pop.

Decomposition:
- defines.v additions: IbDepth, IbPtrBus, IbCntBus, and reuse of InstAddrBus/InstBus plus Flush/ChipEnable constants.
- Sub-module ib_ram:
  - DEPTH x 64-bit register array.
  - Two write ports (addr, data, we) and two asynchronous read ports.
  - Write port 1 is used only for mask 11.
- Pointer and count logic stays in inst_buffer.

Test Plan:
- Reset, then write wpc=0xbfc00000, mask 11, winst0=0x11111111, winst1=0x22222222, no pop -> next cycle valid0=valid1=1, pc0=0xbfc00000, pc1=0xbfc00004, count=2.
- Mask 10 with wpc=0xbfc00008, winst1=0x33333333 into an empty buffer -> next cycle valid0=1, pc0=0xbfc0000c, inst0=0x33333333, valid1=0.
- Write pairs every cycle with issue_cnt=0 -> count increments 2 per cycle; ibuffer_full rises at count=14 (DEPTH 16, margin 4); a write at count=15 with mask 11 is dropped and count stays 15.
- Sustained mask-11 writes with issue_cnt=2 and stall_id=0 across more than 3 full wraps -> count constant and PCs strictly sequential by +4 at the read port; with stall_id=1, pops stop and count rises by 2 per cycle.
- issue_cnt=2 with count=1 and a simultaneous mask-11 write -> rcnt=1 and count becomes 2; the popped PC is the old head.
- Buffer at count=10 with flush=1, wen=1, issue_cnt=2 -> valid0=valid1=0 in the flush cycle; count=0 and ibuffer_full=0 next cycle; the first post-flush write appears at pc0.
